// File: rtl/exe_except_stage_pkg.sv
// Shared CPU definitions for the EXE exception path: the pipelined exception
// bundle, memory access size codes and refetch source indices.
package exe_except_stage_pkg;

   typedef struct packed {
      logic Interrupt;
      logic WrongAddressinIF;
      logic TLBRefillinIF;
      logic TLBInvalidinIF;
      logic ReservedInstruction;
      logic CoprocessorUnusable;
      logic Syscall;
      logic Break;
      logic Eret;
      logic Overflow;
      logic Trap;
      logic RdWrongAddressinMEM;
      logic WrWrongAddressinMEM;
      logic RdTLBRefillinMEM;
      logic RdTLBInvalidinMEM;
      logic WrTLBRefillinMEM;
      logic WrTLBInvalidinMEM;
      logic WrTLBModifiedinMEM;
      logic Refetch;
   } ExceptinPipeType;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int RF_TLBR     = 0;
   localparam int RF_TLBW_EHI = 1;
   localparam int RF_ICACHE   = 2;

   typedef enum logic {
      RA_IDLE  = 1'b0,
      RA_ARMED = 1'b1
   } refetch_state_e;

endpackage

// File: rtl/refetch_arm_fsm.sv
// Remembers a refetch trigger that arrived while EXE had no acceptable
// instruction, for up to REFETCH_HOLD bubble cycles.
module refetch_arm_fsm
   import exe_except_stage_pkg::*;
#(
   parameter int unsigned REFETCH_HOLD = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic trig,
   input  logic accept,
   input  logic flush,
   input  logic hold,
   output logic armed
);

   localparam int unsigned CNT_W = $clog2(REFETCH_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(REFETCH_HOLD);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   refetch_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= RA_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RA_IDLE: begin
            cnt_d = '0;
            if (trig && !accept && !flush) begin
               state_d = RA_ARMED;
               cnt_d   = HOLD_LD;
            end
         end
         RA_ARMED: begin
            if (flush || accept) begin
               state_d = RA_IDLE;
               cnt_d   = '0;
            end else if (trig) begin
               cnt_d = HOLD_LD;
            end else if (!hold) begin
               // A stalled real instruction keeps the window open.
               if (cnt_q == CNT_ONE) begin
                  state_d = RA_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            state_d = RA_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign armed = (state_q == RA_ARMED);

endmodule

// File: rtl/exe_except_stage.sv
// EXE-stage exception merger: combines IF/ID causes with EXE-detected causes
// and registers the bundle towards MEM.
module exe_except_stage
   import exe_except_stage_pkg::*;
#(
   parameter int unsigned NUM_REFETCH_SRC = 3,
   parameter int unsigned ADDR_LSB_W      = 3,
   parameter int unsigned REFETCH_HOLD    = 2,
   parameter int unsigned PC_W            = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       exe_valid,
   input  logic                       exe_stall,
   input  logic                       exe_flush,
   input  logic [PC_W-1:0]            exe_pc,
   input  ExceptinPipeType            exe_except_in,
   input  logic                       overflow_valid,
   input  logic                       trap_valid,
   input  logic                       ld_rd,
   input  logic                       st_wr,
   input  logic [1:0]                 mem_size,
   input  logic                       mem_unaligned_op,
   input  logic [ADDR_LSB_W-1:0]      addr_lsb,
   input  logic [NUM_REFETCH_SRC-1:0] refetch_src,
   output ExceptinPipeType            mem_except_out,
   output logic                       mem_valid_out,
   output logic                       exe_has_except,
   output logic                       refetch_armed
);

   // Bits below the access size must be zero; sizes beyond the checked
   // window saturate to all ones.
   function automatic logic [ADDR_LSB_W-1:0] align_mask(input logic [1:0] sz);
      logic [ADDR_LSB_W-1:0] m;
      for (int i = 0; i < int'(ADDR_LSB_W); i++) m[i] = (i < int'(sz));
      return m;
   endfunction

   logic            trig, accept, mis, armed;
   ExceptinPipeType merged;
   ExceptinPipeType mem_except_d, mem_except_q;
   logic            mem_valid_d, mem_valid_q;

   always_comb begin
      trig   = |refetch_src;
      accept = exe_valid && !exe_stall && !exe_flush && (exe_pc != '0);
      mis    = |(addr_lsb & align_mask(mem_size));

      merged                     = exe_except_in;
      merged.Overflow            = overflow_valid;
      merged.Trap                = trap_valid;
      merged.RdWrongAddressinMEM = ld_rd && !mem_unaligned_op && mis;
      merged.WrWrongAddressinMEM = st_wr && !mem_unaligned_op && mis;
      merged.Refetch             = accept && (trig || armed);
      if (!exe_valid) merged = '0;
   end

   assign exe_has_except = |merged;

   always_comb begin
      mem_valid_d  = mem_valid_q;
      mem_except_d = mem_except_q;
      if (exe_flush) begin
         mem_valid_d  = 1'b0;
         mem_except_d = '0;
      end else if (!exe_stall) begin
         mem_valid_d  = exe_valid;
         mem_except_d = merged;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_valid_q  <= 1'b0;
         mem_except_q <= '0;
      end else begin
         mem_valid_q  <= mem_valid_d;
         mem_except_q <= mem_except_d;
      end
   end

   refetch_arm_fsm #(
      .REFETCH_HOLD (REFETCH_HOLD)
   ) u_refetch_arm (
      .clk    (clk),
      .resetn (resetn),
      .trig   (trig),
      .accept (accept),
      .flush  (exe_flush),
      .hold   (exe_valid && exe_stall),
      .armed  (armed)
   );

   assign mem_except_out = mem_except_q;
   assign mem_valid_out  = mem_valid_q;
   assign refetch_armed  = armed;

endmodule

// File: tb/tb_exe_except_stage.sv
// Randomised scoreboard bench for exe_except_stage against a cycle-level
// behavioural model of the exception merge and refetch window.
module tb_exe_except_stage;
   import exe_except_stage_pkg::*;

   localparam int NSRC  = 3;
   localparam int ALW   = 3;
   localparam int HOLD  = 2;
   localparam int PCW   = 32;

   logic                  clk = 1'b0;
   logic                  resetn, exe_valid, exe_stall, exe_flush;
   logic [PCW-1:0]        exe_pc;
   ExceptinPipeType       exe_except_in;
   logic                  overflow_valid, trap_valid, ld_rd, st_wr;
   logic [1:0]            mem_size;
   logic                  mem_unaligned_op;
   logic [ALW-1:0]        addr_lsb;
   logic [NSRC-1:0]       refetch_src;
   ExceptinPipeType       mem_except_out;
   logic                  mem_valid_out, exe_has_except, refetch_armed;

   exe_except_stage #(
      .NUM_REFETCH_SRC (NSRC),
      .ADDR_LSB_W      (ALW),
      .REFETCH_HOLD    (HOLD),
      .PC_W            (PCW)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .exe_valid        (exe_valid),
      .exe_stall        (exe_stall),
      .exe_flush        (exe_flush),
      .exe_pc           (exe_pc),
      .exe_except_in    (exe_except_in),
      .overflow_valid   (overflow_valid),
      .trap_valid       (trap_valid),
      .ld_rd            (ld_rd),
      .st_wr            (st_wr),
      .mem_size         (mem_size),
      .mem_unaligned_op (mem_unaligned_op),
      .addr_lsb         (addr_lsb),
      .refetch_src      (refetch_src),
      .mem_except_out   (mem_except_out),
      .mem_valid_out    (mem_valid_out),
      .exe_has_except   (exe_has_except),
      .refetch_armed    (refetch_armed)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              rn, v, st, fl, ov, tr, ld, sw, una;
      logic [31:0]     pc;
      ExceptinPipeType ein;
      logic [1:0]      sz;
      logic [2:0]      al;
      logic [2:0]      rs;
   } stim_t;

   typedef struct {
      logic            has;
      logic            vld;
      ExceptinPipeType bun;
      logic            armed;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: what MEM currently holds and the refetch window.
   bit              m_vld   = 1'b0;
   ExceptinPipeType m_bun   = '0;
   bit              m_armed = 1'b0;
   int              m_left  = 0;

   function automatic stim_t nop();
      stim_t s;
      s = '{rn: 1'b1, v: 1'b0, st: 1'b0, fl: 1'b0, ov: 1'b0, tr: 1'b0, ld: 1'b0,
            sw: 1'b0, una: 1'b0, pc: 32'h8000_0100, ein: '0, sz: 2'd0, al: 3'd0, rs: 3'd0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t            e;
      ExceptinPipeType b;
      bit              trig, acc, mis;
      int              bytes;
      @(negedge clk);
      resetn = s.rn; exe_valid = s.v; exe_stall = s.st; exe_flush = s.fl;
      exe_pc = s.pc; exe_except_in = s.ein; overflow_valid = s.ov; trap_valid = s.tr;
      ld_rd = s.ld; st_wr = s.sw; mem_size = s.sz; mem_unaligned_op = s.una;
      addr_lsb = s.al; refetch_src = s.rs;

      trig  = (s.rs != 0);
      acc   = s.v && !s.st && !s.fl && (s.pc != 0);
      bytes = 1 << ((int'(s.sz) > ALW) ? ALW : int'(s.sz));
      mis   = (int'(s.al) % bytes) != 0;
      b = s.ein;
      b.Overflow            = s.ov;
      b.Trap                = s.tr;
      b.RdWrongAddressinMEM = s.ld && !s.una && mis;
      b.WrWrongAddressinMEM = s.sw && !s.una && mis;
      b.Refetch             = acc && (trig || m_armed);
      if (!s.v) b = '0;
      e.has = (b != '0);

      if (!s.rn) begin
         m_vld = 1'b0; m_bun = '0; m_armed = 1'b0; m_left = 0;
      end else begin
         if (s.fl) begin
            m_vld = 1'b0; m_bun = '0;
         end else if (!s.st) begin
            m_vld = s.v; m_bun = b;
         end
         if (!m_armed) begin
            if (trig && !acc && !s.fl) begin
               m_armed = 1'b1; m_left = HOLD;
            end
         end else if (s.fl || acc) begin
            m_armed = 1'b0;
         end else if (trig) begin
            m_left = HOLD;
         end else if (!(s.v && s.st)) begin
            m_left--;
            if (m_left == 0) m_armed = 1'b0;
         end
      end
      e.vld = m_vld; e.bun = m_bun; e.armed = m_armed;
      q.push_back(e);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, expv);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (q.size() == 0) continue;
         e = q.pop_front();
         check("exe_has_except", 64'(exe_has_except), 64'(e.has));
         @(posedge clk);
         #1;
         check("mem_valid_out", 64'(mem_valid_out), 64'(e.vld));
         check("mem_except_out", 64'(mem_except_out), 64'(e.bun));
         check("refetch_armed", 64'(refetch_armed), 64'(e.armed));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      resetn = 1'b0; exe_valid = 1'b0; exe_stall = 1'b0; exe_flush = 1'b0;
      exe_pc = '0; exe_except_in = '0; overflow_valid = 1'b0; trap_valid = 1'b0;
      ld_rd = 1'b0; st_wr = 1'b0; mem_size = '0; mem_unaligned_op = 1'b0;
      addr_lsb = '0; refetch_src = '0;

      s = nop(); s.rn = 1'b0; step(s); step(s);

      // Load word alignment, aligned load, dword store, exempt store, byte store.
      s = nop(); s.v = 1; s.ld = 1; s.sz = SZ_W; s.al = 3'b010; step(s);
      s.al = 3'b100; step(s);
      s = nop(); s.v = 1; s.sw = 1; s.sz = SZ_D; s.al = 3'b100; step(s);
      s.una = 1; step(s);
      s = nop(); s.v = 1; s.sw = 1; s.sz = SZ_B; s.al = 3'b111; step(s);
      s = nop(); s.v = 1; s.sw = 1; s.sz = SZ_H; s.al = 3'b001; step(s);

      // Trigger during a bubble, consumed by the next instruction.
      s = nop(); s.rs = 3'b001; step(s);
      s = nop(); s.v = 1; s.pc = 32'hBFC0_0380; step(s);
      s = nop(); step(s);

      // Trigger, then three bubbles: window expires, later instruction is clean.
      s = nop(); s.rs = 3'(1 << RF_ICACHE); step(s);
      s = nop(); step(s); step(s); step(s);
      s.v = 1; step(s);

      // Trigger alongside an instruction at pc 0: arms, next pc carries it.
      s = nop(); s.v = 1; s.pc = 32'h0; s.rs = 3'(1 << RF_TLBW_EHI); step(s);
      s = nop(); s.v = 1; s.pc = 32'h8000_0000; step(s);

      // Flush while armed.
      s = nop(); s.rs = 3'(1 << RF_TLBR); step(s);
      s = nop(); s.v = 1; s.fl = 1; step(s);
      s = nop(); step(s);

      // Overflow under stall, release, then reset in the middle of a stall.
      s = nop(); s.v = 1; s.tr = 1; step(s);
      s = nop(); s.v = 1; s.ov = 1; s.st = 1; step(s); step(s); step(s);
      s.st = 0; step(s);
      s.st = 1; step(s);
      s.rn = 0; step(s);
      s = nop(); step(s);

      for (int i = 0; i < 1500; i++) begin
         s = nop();
         s.rn  = ($urandom_range(0, 49) != 0);
         s.v   = ($urandom_range(0, 9) < 7);
         s.st  = ($urandom_range(0, 4) == 0);
         s.fl  = ($urandom_range(0, 9) == 0);
         s.pc  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         s.ein = ExceptinPipeType'(19'($urandom & $urandom & $urandom));
         s.ov  = ($urandom_range(0, 7) == 0);
         s.tr  = ($urandom_range(0, 7) == 0);
         s.ld  = ($urandom_range(0, 2) == 0);
         s.sw  = ($urandom_range(0, 2) == 0);
         s.sz  = 2'($urandom_range(0, 3));
         s.una = ($urandom_range(0, 5) == 0);
         s.al  = 3'($urandom_range(0, 7));
         s.rs  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         step(s);
      end

      repeat (4) @(posedge clk);
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got=%0d pending expected=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exe_except_stage.md
Name: exe_except_stage

Overview:
- Parametrised successor of the EXE-stage exception merger. It merges the fields carried in from IF/ID with the EXE-detected causes: overflow, trap, load/store misalignment and refetch.
- Generalised in access width (byte to doubleword) and in number of refetch sources.
- Adds a refetch-arm FSM so a refetch trigger that leaves MEM while EXE holds a bubble is not lost.
- Drives the registered EXE→MEM exception bundle, with stall/flush handling, between EXE and MEM.

Parameters:
- NUM_REFETCH_SRC, 3, number of independent refetch triggers (TLBR, TLBW/EntryHi write, ICache op, …).
- ADDR_LSB_W, 3, low address bits checked; max access size is 2^ADDR_LSB_W bytes.
- REFETCH_HOLD, 2, bubble cycles an armed refetch survives without a valid EXE instruction; ≥1.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- exe_valid  in  1  EXE holds a real instruction
- exe_stall  in  1  EXE→MEM register holds
- exe_flush  in  1  kill EXE contents this cycle
- exe_pc  in  PC_W  EXE instruction PC
- exe_except_in  in  ExceptinPipeType  causes carried from IF/ID
- overflow_valid  in  1  ALU overflow
- trap_valid  in  1  trap condition true
- ld_rd  in  1  load instruction
- st_wr  in  1  store instruction
- mem_size  in  2  log2 access bytes: 0=B, 1=H, 2=W, 3=D
- mem_unaligned_op  in  1  LWL/LWR/SWL/SWR class; exempt from alignment check
- addr_lsb  in  ADDR_LSB_W  low bits of effective address
- refetch_src  in  NUM_REFETCH_SRC  per-source refetch trigger from MEM
- mem_except_out  out  ExceptinPipeType  registered merged bundle to MEM
- mem_valid_out  out  1  registered instruction valid to MEM
- exe_has_except  out  1  combinational OR of all merged causes; hazard unit uses it
- refetch_armed  out  1  FSM in ARMED

Behaviour:
- Reset (resetn=0 at clk edge):
  - mem_except_out and mem_valid_out are cleared to all-zero.
  - FSM goes to IDLE and hold counter is 0.
  - Reset overrides stall and flush.
- Pass-through fields: Interrupt, WrongAddressinIF, ReservedInstruction, CoprocessorUnusable, Syscall, Break, Eret and all TLB* fields are copied from exe_except_in.
- Overflow = overflow_valid & exe_valid. Trap = trap_valid & exe_valid.
- Alignment check:
  - mask = (1 << min(mem_size, ADDR_LSB_W)) − 1.
  - mis = |(addr_lsb & mask).
  - RdWrongAddressinMEM = exe_valid & ld_rd & !mem_unaligned_op & mis.
  - WrWrongAddressinMEM = exe_valid & st_wr & !mem_unaligned_op & mis.
  - mem_size=0 never faults. If ld_rd and st_wr are both set, both flags may assert.
- Refetch:
  - trig = |refetch_src.
  - accept = exe_valid & !exe_stall & !exe_flush & (exe_pc ≠ 0).
  - Refetch = accept & (trig | state==ARMED).
- Refetch-arm FSM:
  - IDLE:
    - If trig & !accept & !exe_flush, go to ARMED and load cnt = REFETCH_HOLD.
    - If trig & accept, stay IDLE; the trigger is consumed directly.
  - ARMED:
    - exe_flush → IDLE, cnt = 0. Flush has priority.
    - Else accept → IDLE; that instruction carries Refetch.
    - Else trig → reload cnt = REFETCH_HOLD.
    - Else if cnt==1 → IDLE; else cnt−1.
    - A stalled valid instruction does not decrement cnt.
  - refetch_armed = (state==ARMED).
- Output register priority: resetn=0 > exe_flush > exe_stall > load.
  - exe_flush: mem_valid_out=0 and mem_except_out=0 next edge.
  - exe_stall: outputs hold.
  - Load: mem_valid_out=exe_valid; mem_except_out=merged bundle, zero when exe_valid=0.
- Latency: causes appear at MEM one cycle after acceptance. exe_has_except is zero-latency.
- Simultaneous trig and flush in IDLE: no arm. The flush redirects fetch, so nothing is lost.

Decomposition:
- Shared CPU package holds:
  - ExceptinPipeType with Refetch, Trap and the Rd/Wr TLB fields.
  - Size codes SZ_B/SZ_H/SZ_W/SZ_D.
  - Refetch source index constants RF_TLBR, RF_TLBW_EHI, RF_ICACHE.
- One sub-module: refetch_arm_fsm (IDLE/ARMED states plus hold counter; inputs trig, accept, flush).

Test Plan:
- Load word, mem_size=2, addr_lsb=3'b010, exe_valid=1, no stall → next cycle RdWrongAddressinMEM=1, mem_valid_out=1. With addr_lsb=3'b100: no fault.
- Store dword, mem_size=3, addr_lsb=3'b100 → WrWrongAddressinMEM=1. Same store with mem_unaligned_op=1 → 0. Byte store at 3'b111 → 0.
- refetch_src=3'b001 for one cycle while exe_valid=0:
  - Expect refetch_armed=1.
  - exe_valid=1 with pc=0xBFC00380 on the next cycle → Refetch=1 at MEM and armed drops.
  - With REFETCH_HOLD=2 and three bubbles instead, armed drops after 2 cycles and no Refetch is produced.
- Trigger plus accepted instruction with pc=0 in the same cycle → Refetch=0, FSM arms. The next valid pc=0x80000000 gets Refetch=1.
- ARMED, exe_flush=1 together with exe_valid=1 → next cycle mem_valid_out=0, bundle all zero, FSM IDLE.
- overflow_valid=1 under exe_stall=1 for 3 cycles → outputs hold the previous values. Release → Overflow=1 at MEM. resetn=0 mid-stall → all outputs 0 next edge.
